xgmii_frame_gen: RTL and testbench

Test-traffic source for the 10GBASE-R transmit path. Emits well-formed 64-bit XGMII frames (start/preamble/SFD word, incrementing payload, CRC-32 FCS, terminate, programmable inter-packet gap) on an `xgmii64_t` bus that drives the `xgmii_tx` input of `tr_baser_wrapper`. Gated by the wrapper's TX-ready indication. Counts sent and aborted frames for the bench and for on-chip link bring-up.

---
 rtl/gtype.sv | 34 +++
 rtl/crc32_d64.sv | 25 ++
 rtl/xgmii_frame_gen.sv | 158 +++++++++++++++
 tb/tb_xgmii_frame_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gtype.sv
// Shared XGMII word type and control-character constants for the 10GBASE-R
// transmit/receive test path.
package gtype;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
    logic        ena;
  } xgmii64_t;

  localparam logic [7:0] XGMII_CH_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_CH_START = 8'hFB;
  localparam logic [7:0] XGMII_CH_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_CH_ERROR = 8'hFE;
  localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
  localparam logic [7:0] XGMII_SFD      = 8'hD5;

  localparam logic [63:0] XGMII_IDLE_DATA = {8{XGMII_CH_IDLE}};
  localparam logic [63:0] XGMII_ERR_DATA  = {8{XGMII_CH_ERROR}};
  // Lane 0 carries /S/, lane 7 the SFD.
  localparam logic [63:0] XGMII_PRE_DATA  = {XGMII_SFD, {6{XGMII_PREAMBLE}}, XGMII_CH_START};

  // Idle word as seen while the bus is not yet enabled (reset value).
  localparam xgmii64_t XGMII_IDLE_WORD = '{data: XGMII_IDLE_DATA, ctrl: 8'hFF, ena: 1'b0};

  // Reflected IEEE 802.3 CRC-32 polynomial.
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;

  // Build an enabled XGMII word.
  function automatic xgmii64_t xgmii_word(input logic [63:0] data, input logic [7:0] ctrl);
    xgmii_word = '{data: data, ctrl: ctrl, ena: 1'b1};
  endfunction

endpackage

// File: rtl/crc32_d64.sv
// Combinational CRC-32 (IEEE 802.3, reflected) next state over one 64-bit
// word. Byte 0 sits in data[7:0] and every byte is consumed LSB first, so the
// bit stream order is simply data[0], data[1], ... data[63].
module crc32_d64
  import gtype::*;
(
  input  logic [31:0] i_crc,
  input  logic [63:0] i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_acc;

  // Unrolled serial LFSR; synthesis flattens it into an XOR network.
  always_comb begin
    w_acc = i_crc;
    for (int i = 0; i < 64; i++) begin
      if (w_acc[0] ^ i_data[i]) w_acc = (w_acc >> 1) ^ CRC32_POLY_REFL;
      else                      w_acc = w_acc >> 1;
    end
  end

  assign o_crc = w_acc;

endmodule

// File: rtl/xgmii_frame_gen.sv
// XGMII test-traffic source: PRE word, incrementing payload, CRC-32 FCS in the
// TERM word, then a programmable idle gap. One 64-bit word leaves per cycle.
module xgmii_frame_gen
  import gtype::*;
#(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
)
(
  input  logic             i_clk_156,
  input  logic             i_rst_156_n,
  input  logic             i_cfg_start,
  input  logic             i_cfg_stop,
  input  logic [LEN_W-1:0] i_cfg_len_words,
  input  logic [3:0]       i_cfg_ipg_words,
  input  logic [CNT_W-1:0] i_cfg_frame_num,
  input  logic             i_xgmii_tx_rdy,
  output xgmii64_t         o_xgmii_tx,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_frames_sent,
  output logic [CNT_W-1:0] o_frames_aborted
);

  typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_DATA, ST_TERM, ST_IPG} state_t;

  // r_state names the word currently on the bus.
  state_t           r_state;
  xgmii64_t         r_tx;
  logic             r_busy;
  logic             r_done;
  logic [31:0]      r_sent;
  logic [CNT_W-1:0] r_aborted;
  logic [7:0]       r_seq;
  logic [7:0]       r_byte_base;
  logic [31:0]      r_crc;
  logic [LEN_W-1:0] r_len;
  logic [3:0]       r_ipg;
  logic             r_continuous;
  logic [CNT_W-1:0] r_frames_left;
  logic [LEN_W-1:0] r_words_left;
  logic [3:0]       r_gap;
  logic             r_abort;

  logic [63:0]      w_payload;
  logic [31:0]      w_crc_next;

  // Next payload word: byte lane gi carries base + gi (mod 256).
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign w_payload[8*gi +: 8] = r_byte_base + 8'(gi);
    end
  endgenerate

  crc32_d64 u_crc (
    .i_crc  (r_crc),
    .i_data (w_payload),
    .o_crc  (w_crc_next)
  );

  // Frame sequencer: picks the next word each cycle, all outputs registered.
  always_ff @(posedge i_clk_156 or negedge i_rst_156_n) begin
    if (!i_rst_156_n) begin
      r_state       <= ST_IDLE;
      r_tx          <= XGMII_IDLE_WORD;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_sent        <= '0;
      r_aborted     <= '0;
      r_seq         <= '0;
      r_byte_base   <= '0;
      r_crc         <= '1;
      r_len         <= '0;
      r_ipg         <= '0;
      r_continuous  <= 1'b0;
      r_frames_left <= '0;
      r_words_left  <= '0;
      r_gap         <= '0;
      r_abort       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_cfg_start && i_xgmii_tx_rdy && !r_busy) begin
            r_len         <= (i_cfg_len_words == '0) ? LEN_W'(1) : i_cfg_len_words;
            r_ipg         <= (i_cfg_ipg_words == 4'd0) ? 4'd1 : i_cfg_ipg_words;
            r_continuous  <= (i_cfg_frame_num == '0);
            r_frames_left <= i_cfg_frame_num - CNT_W'(1);
            r_busy        <= 1'b1;
            r_state       <= ST_PRE;
            r_tx          <= xgmii_word(XGMII_PRE_DATA, 8'h01);
            r_byte_base   <= r_seq;
            r_seq         <= r_seq + 8'd1;
            r_crc         <= '1;
          end else begin
            r_tx <= xgmii_word(XGMII_IDLE_DATA, 8'hFF);
          end
        end
        ST_PRE, ST_DATA: begin
          if (!i_xgmii_tx_rdy) begin
            // The error word takes an extra leading cycle of the gap.
            r_tx      <= xgmii_word(XGMII_ERR_DATA, 8'hFF);
            r_state   <= ST_IPG;
            r_gap     <= r_ipg;
            r_abort   <= 1'b1;
            if (r_aborted != '1) r_aborted <= r_aborted + CNT_W'(1);
          end else if (r_state == ST_DATA && r_words_left == '0) begin
            r_tx    <= xgmii_word({{3{XGMII_CH_IDLE}}, XGMII_CH_TERM, ~r_crc}, 8'hF0);
            r_state <= ST_TERM;
            r_sent  <= r_sent + 32'd1;
          end else begin
            r_tx         <= xgmii_word(w_payload, 8'h00);
            r_crc        <= w_crc_next;
            r_byte_base  <= r_byte_base + 8'd8;
            r_words_left <= (r_state == ST_PRE) ? r_len - LEN_W'(1) : r_words_left - LEN_W'(1);
            r_state      <= ST_DATA;
          end
        end
        ST_TERM: begin
          r_tx    <= xgmii_word(XGMII_IDLE_DATA, 8'hFF);
          r_state <= ST_IPG;
          r_gap   <= r_ipg - 4'd1;
        end
        ST_IPG: begin
          if (r_gap != 4'd0) begin
            r_tx  <= xgmii_word(XGMII_IDLE_DATA, 8'hFF);
            r_gap <= r_gap - 4'd1;
          end else if (!r_abort && !i_cfg_stop && (r_continuous || r_frames_left != '0)) begin
            if (!r_continuous) r_frames_left <= r_frames_left - CNT_W'(1);
            r_state     <= ST_PRE;
            r_tx        <= xgmii_word(XGMII_PRE_DATA, 8'h01);
            r_byte_base <= r_seq;
            r_seq       <= r_seq + 8'd1;
            r_crc       <= '1;
          end else begin
            r_tx    <= xgmii_word(XGMII_IDLE_DATA, 8'hFF);
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_abort <= 1'b0;
          end
        end
        default: begin
          r_tx    <= xgmii_word(XGMII_IDLE_DATA, 8'hFF);
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_xgmii_tx       = r_tx;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_frames_sent    = r_sent;
  assign o_frames_aborted = r_aborted;

endmodule

// File: tb/tb_xgmii_frame_gen.sv
// Bench for xgmii_frame_gen: table of run configurations, hand sequences for
// abort / continuous-stop / reset, and random runs against a frame-level model.
module tb_xgmii_frame_gen;
  import gtype::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, rdy;
  logic [7:0]  len;
  logic [3:0]  ipg;
  logic [15:0] num;
  xgmii64_t    tx;
  logic        busy, done;
  logic [31:0] sent;
  logic [15:0] aborted;

  xgmii_frame_gen #(.LEN_W(8), .CNT_W(16)) dut (
    .i_clk_156        (clk),
    .i_rst_156_n      (rst_n),
    .i_cfg_start      (start),
    .i_cfg_stop       (stop),
    .i_cfg_len_words  (len),
    .i_cfg_ipg_words  (ipg),
    .i_cfg_frame_num  (num),
    .i_xgmii_tx_rdy   (rdy),
    .o_xgmii_tx       (tx),
    .o_busy           (busy),
    .o_done           (done),
    .o_frames_sent    (sent),
    .o_frames_aborted (aborted)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [63:0] d; logic [7:0] c; logic e; } wd_t;
  typedef struct { int len; int ipg; int num; int exp_busy; int exp_sent; logic [63:0] exp_d0; } vec_t;

  localparam wd_t IDLE_W = '{64'h0707070707070707, 8'hFF, 1'b1};

  wd_t         exp_q[$];
  wd_t         got_q[$];
  logic [7:0]  pay_q[$];
  logic [31:0] crc_tab[256];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          model_seq = 0;
  logic [31:0] exp_sent = 0;
  int          exp_aborted = 0;
  int          n_busy;
  bit          run_fin;
  xgmii64_t    done_word;
  logic        done_busy;
  vec_t        vecs[5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic void build_tab();
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end
  endfunction

  // Byte-at-a-time table CRC-32 of pay_q, returned as the FCS value.
  function automatic logic [31:0] sw_crc_pay();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (pay_q[i]) c = crc_tab[c[7:0] ^ pay_q[i]] ^ (c >> 8);
    return ~c;
  endfunction

  // Expected word stream (busy cycles only) for a whole run.
  function automatic void model_run(input int l, input int g, input int n, input int nstop, input int drop_pos);
    int leff, ieff, nfr;
    wd_t fw[$];
    logic [63:0] w;
    leff = (l == 0) ? 1 : l;
    ieff = (g == 0) ? 1 : g;
    nfr  = (n == 0) ? nstop : n;
    exp_q.delete();
    for (int f = 0; f < nfr; f++) begin
      pay_q.delete();
      for (int b = 0; b < 8 * leff; b++) pay_q.push_back(8'((model_seq + b) % 256));
      model_seq++;
      fw.delete();
      fw.push_back('{64'hD5555555555555FB, 8'h01, 1'b1});
      for (int k = 0; k < leff; k++) begin
        for (int i = 0; i < 8; i++) w[8*i +: 8] = pay_q[8*k + i];
        fw.push_back('{w, 8'h00, 1'b1});
      end
      fw.push_back('{{32'h070707FD, sw_crc_pay()}, 8'hF0, 1'b1});
      if (drop_pos > 0 && f == 0) begin
        for (int p = 0; p < drop_pos; p++) exp_q.push_back(fw[p]);
        exp_q.push_back('{64'hFEFEFEFEFEFEFEFE, 8'hFF, 1'b1});
        for (int k = 0; k < ieff; k++) exp_q.push_back(IDLE_W);
        if (exp_aborted < 65535) exp_aborted++;
        return;
      end
      foreach (fw[p]) exp_q.push_back(fw[p]);
      exp_sent++;
      for (int k = 0; k < ieff; k++) exp_q.push_back(IDLE_W);
    end
  endfunction

  function automatic wd_t got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 'x;
  endfunction

  function automatic wd_t exp_at(input int i);
    if (i < exp_q.size()) return exp_q[i];
    return 'x;
  endfunction

  task automatic check_stream(input string name);
    int bad, n;
    bad = -1;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n && bad < 0; i++) if (got_q[i] !== exp_q[i]) bad = i;
    if (bad < 0 && got_q.size() != exp_q.size()) bad = n;
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL %s: word %0d got %h expected %h (lengths %0d/%0d)",
               name, bad, got_at(bad), exp_at(bad), got_q.size(), exp_q.size());
    end
  endtask

  // Pulse start, then record every busy word until done. Optionally raise
  // stop in frame stop_frame, drop ready at frame position drop_pos-1, and
  // scramble cfg inputs / start while the run is in progress.
  task automatic start_and_capture(input int l, input int g, input int n,
                                   input int stop_frame, input int drop_pos, input bit scramble);
    int pre_cnt, pos;
    pre_cnt = 0; pos = 0;
    len = 8'(l); ipg = 4'(g); num = 16'(n); start = 1'b1;
    got_q.delete(); n_busy = 0; run_fin = 1'b0;
    for (int k = 0; k < exp_q.size() + 8 && !run_fin; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        run_fin = 1'b1; done_word = tx; done_busy = busy;
      end else begin
        got_q.push_back('{tx.data, tx.ctrl, tx.ena});
        if (busy) n_busy++;
        if (tx.ctrl == 8'h01 && tx.data[7:0] == 8'hFB) begin pre_cnt++; pos = 0; end
        else pos++;
        if (stop_frame > 0 && pre_cnt == stop_frame && pos == 1) stop = 1'b1;
        if (drop_pos > 0 && pre_cnt == 1 && pos == drop_pos - 1) rdy = 1'b0;
        if (scramble && busy) begin
          len   = 8'($urandom);
          ipg   = 4'($urandom);
          num   = 16'($urandom);
          start = ($urandom_range(0, 2) == 0);
        end
      end
    end
    rdy = 1'b1; stop = 1'b0; start = 1'b0;
    check("run_done_seen", 64'(run_fin), 64'd1);
    check("done_busy_low", 64'(done_busy), 64'd0);
    check("done_word_ctrl", 64'(done_word.ctrl), 64'hFF);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    $display("run len=%0d ipg=%0d num=%0d words=%0d sent=%0d aborted=%0d", l, g, n, got_q.size(), sent, aborted);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] sent_before;
    int rl, rg, rn, rd;
    build_tab();
    vecs[0] = '{8,   1,  1, 11,  1, 64'h0706050403020100};
    vecs[1] = '{2,   2,  3, 18,  3, 64'h0807060504030201};
    vecs[2] = '{0,   0,  2,  8,  2, 64'h0B0A090807060504};
    vecs[3] = '{3,  15,  1, 20,  1, 64'h0D0C0B0A09080706};
    vecs[4] = '{255, 1,  1, 258, 1, 64'h0E0D0C0B0A090807};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; rdy = 1'b1;
    len = 8'd8; ipg = 4'd1; num = 16'd1;
    repeat (2) @(posedge clk); #1;
    check("rst_data", tx.data, 64'h0707070707070707);
    check("rst_ctrl", 64'(tx.ctrl), 64'hFF);
    check("rst_ena", 64'(tx.ena), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sent", 64'(sent), 64'd0);
    check("rst_aborted", 64'(aborted), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ena", 64'(tx.ena), 64'd1);
    check("post_rst_ctrl", 64'(tx.ctrl), 64'hFF);

    // Start with ready low stays in IDLE.
    rdy = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("nordy_busy", 64'(busy), 64'd0);
    check("nordy_ctrl", 64'(tx.ctrl), 64'hFF);
    rdy = 1'b1;
    @(posedge clk); #1;
    check("nordy_stay", 64'(busy), 64'd0);

    for (int v = 0; v < 5; v++) begin
      sent_before = sent;
      model_run(vecs[v].len, vecs[v].ipg, vecs[v].num, 0, 0);
      start_and_capture(vecs[v].len, vecs[v].ipg, vecs[v].num, 0, 0, v[0]);
      check_stream($sformatf("vec%0d_stream", v));
      check($sformatf("vec%0d_busy_cycles", v), 64'(n_busy), 64'(vecs[v].exp_busy));
      check($sformatf("vec%0d_first_data", v), got_at(1).d, vecs[v].exp_d0);
      check($sformatf("vec%0d_sent_delta", v), 64'(sent - sent_before), 64'(vecs[v].exp_sent));
      check($sformatf("vec%0d_aborted", v), 64'(aborted), 64'd0);
      if (v == 0) begin
        pay_q.delete();
        for (int b = 0; b < 64; b++) pay_q.push_back(8'(b));
        check("fcs_bytes_00_3f", 64'(got_at(9).d[31:0]), 64'(sw_crc_pay()));
        check("term_ctrl", 64'(got_at(9).c), 64'hF0);
      end
    end

    // Ready drop while the 3rd data word is on the bus.
    sent_before = sent;
    model_run(8, 1, 1, 0, 4);
    start_and_capture(8, 1, 1, 0, 4, 1'b0);
    check_stream("drop_stream");
    check("drop_err_word", got_at(4).d, 64'hFEFEFEFEFEFEFEFE);
    check("drop_aborted", 64'(aborted), 64'd1);
    check("drop_sent_same", 64'(sent), 64'(sent_before));

    // Continuous run stopped during the data of frame 5.
    sent_before = sent;
    model_run(2, 1, 0, 5, 0);
    start_and_capture(2, 1, 0, 5, 0, 1'b0);
    check_stream("cont_stream");
    check("cont_sent_delta", 64'(sent - sent_before), 64'd5);

    // Random runs with mid-run cfg scrambling and occasional ready drops.
    for (int r = 0; r < 8; r++) begin
      rl = $urandom_range(0, 12);
      rg = $urandom_range(0, 5);
      rn = $urandom_range(1, 3);
      rd = ($urandom_range(0, 2) == 0) ? $urandom_range(1, ((rl == 0) ? 1 : rl) + 1) : 0;
      model_run(rl, rg, rn, 0, rd);
      start_and_capture(rl, rg, rn, 0, rd, 1'b1);
      check_stream($sformatf("rand%0d_stream", r));
      check($sformatf("rand%0d_sent", r), 64'(sent), 64'(exp_sent));
      check($sformatf("rand%0d_aborted", r), 64'(aborted), 64'(exp_aborted));
    end

    // Asynchronous reset in the middle of DATA.
    len = 8'd8; ipg = 4'd1; num = 16'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_before_ctrl", 64'(tx.ctrl), 64'h00);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data", tx.data, 64'h0707070707070707);
    check("mid_rst_ctrl", 64'(tx.ctrl), 64'hFF);
    check("mid_rst_ena", 64'(tx.ena), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_sent", 64'(sent), 64'd0);
    check("mid_rst_aborted", 64'(aborted), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("after_rst_ena", 64'(tx.ena), 64'd1);
    check("after_rst_idle", tx.data, 64'h0707070707070707);
    check("after_rst_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
